// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - request/grant port bundle for one ram_arbiter client
interface ram_arbiter_if;
  logic       req;
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       gnt;
  logic       ack;
  logic [7:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, ack, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter driving a 16x8 single-port RAM
module ram_arbiter (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave p0,
  ram_arbiter_if.slave p1,
  output logic         ram_read_en,
  output logic         ram_write_en,
  output logic [3:0]   ram_address,
  inout  wire  [7:0]   ram_data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  state_t     state, state_d;
  logic       sel, sel_d;
  logic       last_grant, last_grant_d;
  logic       lat_we, lat_we_d;
  logic [7:0] lat_wdata, lat_wdata_d;
  logic [3:0] addr_d;
  logic       gnt0, gnt0_d, gnt1, gnt1_d;
  logic       ack0, ack0_d, ack1, ack1_d;
  logic [7:0] rdata0, rdata0_d, rdata1, rdata1_d;
  logic       re_d, we_en_d;
  logic       data_oe, data_oe_d;
  logic       any_req, pick;

  assign any_req = p0.req | p1.req;
  // pick = 1 selects port 1: sole requester, or the tie loser from last time
  assign pick    = p1.req & (~p0.req | ~last_grant);

  assign p0.gnt   = gnt0;
  assign p1.gnt   = gnt1;
  assign p0.ack   = ack0;
  assign p1.ack   = ack1;
  assign p0.rdata = rdata0;
  assign p1.rdata = rdata1;

  assign ram_data = data_oe ? lat_wdata : 8'hzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= 1'b0;
      last_grant   <= 1'b1;
      lat_we       <= 1'b0;
      lat_wdata    <= 8'h00;
      ram_address  <= 4'h0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= 8'h00;
      rdata1       <= 8'h00;
      ram_read_en  <= 1'b0;
      ram_write_en <= 1'b0;
      data_oe      <= 1'b0;
    end else begin
      state        <= state_d;
      sel          <= sel_d;
      last_grant   <= last_grant_d;
      lat_we       <= lat_we_d;
      lat_wdata    <= lat_wdata_d;
      ram_address  <= addr_d;
      gnt0         <= gnt0_d;
      gnt1         <= gnt1_d;
      ack0         <= ack0_d;
      ack1         <= ack1_d;
      rdata0       <= rdata0_d;
      rdata1       <= rdata1_d;
      ram_read_en  <= re_d;
      ram_write_en <= we_en_d;
      data_oe      <= data_oe_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Computes the value every registered output takes after the coming edge
  always_comb begin
    sel_d        = sel;
    last_grant_d = last_grant;
    lat_we_d     = lat_we;
    lat_wdata_d  = lat_wdata;
    addr_d       = ram_address;
    gnt0_d       = gnt0;
    gnt1_d       = gnt1;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0;
    rdata1_d     = rdata1;
    re_d         = 1'b0;
    we_en_d      = 1'b0;
    data_oe_d    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          sel_d        = pick;
          last_grant_d = pick;
          lat_we_d     = pick ? p1.we    : p0.we;
          lat_wdata_d  = pick ? p1.wdata : p0.wdata;
          addr_d       = pick ? p1.addr  : p0.addr;
          gnt0_d       = ~pick;
          gnt1_d       = pick;
          re_d         = ~lat_we_d;
          data_oe_d    = lat_we_d;
        end
      end
      SETUP: begin
        re_d      = ~lat_we;
        we_en_d   = lat_we;
        data_oe_d = lat_we;
      end
      ACCESS: begin
        // data bus stays driven through RELEASE to give the RAM hold time
        data_oe_d = lat_we;
        ack0_d    = ~sel;
        ack1_d    = sel;
        if (!lat_we) begin
          if (sel) rdata1_d = ram_data;
          else     rdata0_d = ram_data;
        end
      end
      RELEASE: begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
      end
      default: begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a RAM model and reference model
module tb_ram_arbiter;
  logic       clk;
  logic       rst;
  logic       ram_read_en;
  logic       ram_write_en;
  logic [3:0] ram_address;
  wire  [7:0] ram_data;

  ram_arbiter_if p0_if ();
  ram_arbiter_if p1_if ();

  ram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .p0           (p0_if),
    .p1           (p1_if),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_address  (ram_address),
    .ram_data     (ram_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [16];
  logic [7:0] shadow [16];
  logic       ram_init;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i) ^ 8'h05;
    end else if (ram_write_en) begin
      mem[ram_address] <= ram_data;
    end
  end

  assign ram_data = ram_read_en ? mem[ram_address] : 8'hzz;

  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if (ram_read_en && ram_write_en) begin
        n_fail++;
        $display("FAIL bus_enables: read_en=%0b write_en=%0b, required never both 1", ram_read_en, ram_write_en);
      end
      n_tests++;
      if (ram_read_en && dut.data_oe) begin
        n_fail++;
        $display("FAIL bus_contention: arbiter drives ram_data while read_en=1, required high-Z");
      end
      n_tests++;
      if (p0_if.gnt && p1_if.gnt) begin
        n_fail++;
        $display("FAIL dual_grant: p0_gnt=%0b p1_gnt=%0b, required not both 1", p0_if.gnt, p1_if.gnt);
      end
    end
  end

  task automatic set_port(input int port, input bit req, input bit we, input logic [3:0] addr, input logic [7:0] wdata);
    if (port == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
    end
  endtask

  task automatic access(input int port, input bit we, input logic [3:0] addr, input logic [7:0] wdata,
                        input bit corrupt, output int gnt_at, output int ack_at,
                        output int we_cyc, output int re_cyc, output logic [7:0] rdata);
    gnt_at = -1; ack_at = -1; we_cyc = 0; re_cyc = 0; rdata = 8'h00;
    set_port(port, 1'b1, we, addr, wdata);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ram_write_en) we_cyc++;
      if (ram_read_en)  re_cyc++;
      if (gnt_at < 0 && (port == 0 ? p0_if.gnt : p1_if.gnt)) begin
        gnt_at = i;
        if (corrupt) set_port(port, 1'b1, we, addr ^ 4'hC, 8'h00);
      end
      if (port == 0 ? p0_if.ack : p1_if.ack) begin
        ack_at = i;
        rdata  = (port == 0) ? p0_if.rdata : p1_if.rdata;
        break;
      end
    end
    set_port(port, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_init = 1'b1;
    repeat (2) @(posedge clk);
    #1; ram_init = 1'b0;
    n_tests++;
    if ({p0_if.gnt, p1_if.gnt, p0_if.ack, p1_if.ack, ram_read_en, ram_write_en, dut.data_oe} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt/ack/en/oe=%b, required 0000000",
               {p0_if.gnt, p1_if.gnt, p0_if.ack, p1_if.ack, ram_read_en, ram_write_en, dut.data_oe});
    end
    n_tests++;
    if (p0_if.rdata !== 8'h00 || p1_if.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: p0=%h p1=%h, required 00 00", p0_if.rdata, p1_if.rdata);
    end
    n_tests++;
    if (ram_address !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h, required 0", ram_address);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_write_read();
    int g, a, wc, rc; logic [7:0] rd;
    access(0, 1'b1, 4'hD, 8'h11, 1'b0, g, a, wc, rc, rd);
    n_tests++;
    if (g !== 1 || a !== 3) begin
      n_fail++;
      $display("FAIL write_latency: gnt_at=%0d ack_at=%0d, required 1 3", g, a);
    end
    n_tests++;
    if (wc !== 1 || rc !== 0) begin
      n_fail++;
      $display("FAIL write_enables: write_en cycles=%0d read_en cycles=%0d, required 1 0", wc, rc);
    end
    access(0, 1'b0, 4'hD, 8'h00, 1'b0, g, a, wc, rc, rd);
    n_tests++;
    if (rd !== 8'h11 || a !== 3) begin
      n_fail++;
      $display("FAIL readback_D: rdata=%h ack_at=%0d, required 11 3", rd, a);
    end
    n_tests++;
    if (p1_if.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL p1_rdata_kept: got %h, required 00", p1_if.rdata);
    end
  endtask

  task automatic test_read_preload();
    int g, a, wc, rc; logic [7:0] rd;
    access(1, 1'b0, 4'hE, 8'hFF, 1'b0, g, a, wc, rc, rd);
    n_tests++;
    if (rd !== 8'h0B || p1_if.rdata !== 8'h0B) begin
      n_fail++;
      $display("FAIL read_E: rdata=%h, required 0B", rd);
    end
    n_tests++;
    if (rc !== 2 || wc !== 0) begin
      n_fail++;
      $display("FAIL read_enables: read_en cycles=%0d write_en cycles=%0d, required 2 0", rc, wc);
    end
    n_tests++;
    if (p0_if.rdata !== 8'h11) begin
      n_fail++;
      $display("FAIL p0_rdata_kept: got %h, required 11", p0_if.rdata);
    end
  endtask

  task automatic test_latch();
    int g, a, wc, rc; logic [7:0] rd;
    access(0, 1'b1, 4'h5, 8'h77, 1'b1, g, a, wc, rc, rd);
    access(0, 1'b0, 4'h5, 8'h00, 1'b0, g, a, wc, rc, rd);
    n_tests++;
    if (rd !== 8'h77) begin
      n_fail++;
      $display("FAIL latch_addr5: rdata=%h, required 77", rd);
    end
    access(0, 1'b0, 4'h9, 8'h00, 1'b0, g, a, wc, rc, rd);
    n_tests++;
    if (rd !== 8'h0C) begin
      n_fail++;
      $display("FAIL latch_addr9: rdata=%h, required 0C", rd);
    end
  endtask

  task automatic test_round_robin();
    int order[$]; int when[$]; bit prev0, prev1;
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 4'h1, 8'h00);
    set_port(1, 1'b1, 1'b0, 4'h2, 8'h00);
    @(posedge clk); #1; rst = 1'b0;
    prev0 = 1'b0; prev1 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (p0_if.gnt && !prev0) begin order.push_back(0); when.push_back(i); end
      if (p1_if.gnt && !prev1) begin order.push_back(1); when.push_back(i); end
      prev0 = p0_if.gnt; prev1 = p1_if.gnt;
    end
    set_port(0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_port(1, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (order.size() !== 4) begin
      n_fail++;
      $display("FAIL rr_count: grants=%0d, required 4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (order[k] !== (k % 2) || when[k] !== 1 + 4 * k) begin
          n_fail++;
          $display("FAIL rr_grant%0d: port=%0d cycle=%0d, required port %0d cycle %0d",
                   k, order[k], when[k], k % 2, 1 + 4 * k);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    bit seen, first_done, d0, d1; int first;
    set_port(0, 1'b1, 1'b1, 4'h3, 8'hAA);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (ram_write_en) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_setup: write_en=0 after 10 cycles, required 1");
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({ram_write_en, ram_read_en, dut.data_oe, p0_if.gnt} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_async: we/re/oe/gnt=%b, required 0000",
               {ram_write_en, ram_read_en, dut.data_oe, p0_if.gnt});
    end
    set_port(0, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (2) begin
      @(posedge clk); #1;
      n_tests++;
      if (p0_if.ack !== 1'b0 || p1_if.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_ack: p0_ack=%0b p1_ack=%0b, required 0 0", p0_if.ack, p1_if.ack);
      end
    end
    n_tests++;
    if (p0_if.rdata !== 8'h00 || p1_if.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_rdata: p0=%h p1=%h, required 00 00", p0_if.rdata, p1_if.rdata);
    end
    rst = 1'b0;
    set_port(0, 1'b1, 1'b0, 4'h1, 8'h00);
    set_port(1, 1'b1, 1'b0, 4'h2, 8'h00);
    first = -1; first_done = 1'b0; d0 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 20 && !(d0 && d1); i++) begin
      @(posedge clk); #1;
      if (!first_done && (p0_if.gnt || p1_if.gnt)) begin
        first_done = 1'b1;
        first = p1_if.gnt ? 1 : 0;
      end
      if (p0_if.ack) begin d0 = 1'b1; set_port(0, 1'b0, 1'b0, 4'h0, 8'h00); end
      if (p1_if.ack) begin d1 = 1'b1; set_port(1, 1'b0, 1'b0, 4'h0, 8'h00); end
    end
    set_port(0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_port(1, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge clk); #1;
    n_tests++;
    if (first !== 0 || !(d0 && d1)) begin
      n_fail++;
      $display("FAIL abort_regrant: first=%0d done=%0b%0b, required 0 11", first, d0, d1);
    end
  endtask

  task automatic test_random();
    int rr_last; logic [7:0] exp_rd0, exp_rd1;
    rst = 1'b1; ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0; rst = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = 8'(i) ^ 8'h05;
    rr_last = 1; exp_rd0 = 8'h00; exp_rd1 = 8'h00;
    for (int t = 0; t < 40; t++) begin
      int mask; int order[$]; int exp_order[$]; bit d0, d1;
      bit we [2]; logic [3:0] ad [2]; logic [7:0] wd [2];
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        ad[p] = 4'($urandom_range(0, 15));
        wd[p] = 8'($urandom_range(0, 255));
      end
      if (mask == 3) begin
        exp_order.push_back(rr_last == 1 ? 0 : 1);
        exp_order.push_back(rr_last == 1 ? 1 : 0);
      end else begin
        exp_order.push_back(mask == 1 ? 0 : 1);
      end
      foreach (exp_order[k]) begin
        int p;
        p = exp_order[k];
        if (we[p]) shadow[ad[p]] = wd[p];
        else if (p == 0) exp_rd0 = shadow[ad[p]];
        else exp_rd1 = shadow[ad[p]];
        rr_last = p;
      end
      d0 = (mask & 1) == 0; d1 = (mask & 2) == 0;
      if (!d0) set_port(0, 1'b1, we[0], ad[0], wd[0]);
      if (!d1) set_port(1, 1'b1, we[1], ad[1], wd[1]);
      for (int i = 0; i < 20 && !(d0 && d1); i++) begin
        @(posedge clk); #1;
        if (p0_if.ack) begin d0 = 1'b1; order.push_back(0); set_port(0, 1'b0, 1'b0, 4'h0, 8'h00); end
        if (p1_if.ack) begin d1 = 1'b1; order.push_back(1); set_port(1, 1'b0, 1'b0, 4'h0, 8'h00); end
      end
      set_port(0, 1'b0, 1'b0, 4'h0, 8'h00);
      set_port(1, 1'b0, 1'b0, 4'h0, 8'h00);
      @(posedge clk); #1;
      n_tests++;
      if (order != exp_order) begin
        n_fail++;
        $display("FAIL rand%0d_order: got %p, required %p", t, order, exp_order);
      end
      n_tests++;
      if (p0_if.rdata !== exp_rd0 || p1_if.rdata !== exp_rd1) begin
        n_fail++;
        $display("FAIL rand%0d_rdata: p0=%h p1=%h, required %h %h", t, p0_if.rdata, p1_if.rdata, exp_rd0, exp_rd1);
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; ram_init = 1'b0;
    set_port(0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_port(1, 1'b0, 1'b0, 4'h0, 8'h00);
    test_reset();
    test_write_read();
    test_read_preload();
    test_latch();
    test_round_robin();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
